fwd_scoreboard: RTL and testbench

- Parametrised forwarding/interlock unit for the pipelined core; replaces hard-wired EX/MEM/WB comparators with a DEPTH-entry in-flight result buffer.
- Tracks every in-flight register write from EX to retirement, holds its result data, and supplies forwarded operands for NSRC source registers.
- Raises a load-use stall when a needed producer has not yet produced data.
- Sits beside the ID/EX boundary; the ID stage supplies sources and the EX-out and MEM stages supply results.

---
 rtl/fwd_scoreboard_if.sv | 35 +++
 rtl/fwd_scoreboard.sv | 133 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the ID/EX hazard logic and fwd_scoreboard: issue, load return,
// operand lookup and status. The master drives the pipeline side; the slave is the scoreboard.
interface fwd_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DW     = 32,
  parameter int NSRC   = 2
);
  logic                   advance;
  logic                   flush;
  logic                   issue_valid;
  logic                   issue_regwr;
  logic                   issue_is_load;
  logic [REG_AW-1:0]      issue_rd;
  logic [DW-1:0]          issue_data;
  logic                   ld_valid;
  logic [DW-1:0]          ld_data;
  logic [NSRC*REG_AW-1:0] src_reg;
  logic [NSRC*DW-1:0]     src_rf_data;
  logic [NSRC*DW-1:0]     src_data;
  logic [NSRC-1:0]        fwd_hit;
  logic                   stall;
  logic [31:0]            stall_cnt;

  modport master (
    output advance, flush, issue_valid, issue_regwr, issue_is_load, issue_rd, issue_data,
    output ld_valid, ld_data, src_reg, src_rf_data,
    input  src_data, fwd_hit, stall, stall_cnt
  );

  modport slave (
    input  advance, flush, issue_valid, issue_regwr, issue_is_load, issue_rd, issue_data,
    input  ld_valid, ld_data, src_reg, src_rf_data,
    output src_data, fwd_hit, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// In-flight result buffer that forwards operands and flags load-use stalls.
// Optional stall-cycle counter is built when FWD_SCOREBOARD_PERF_CNT_EN is defined.
module fwd_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DW     = 32,
  parameter int DEPTH  = 3,
  parameter int NSRC   = 2,
  parameter int LD_STG = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  fwd_scoreboard_if.slave  bus
);

  logic              valid_reg [DEPTH];
  logic              regwr_reg [DEPTH];
  logic [REG_AW-1:0] rd_reg    [DEPTH];
  logic              ready_reg [DEPTH];
  logic [DW-1:0]     data_reg  [DEPTH];

  logic              ld_hit;
  logic [NSRC*DW-1:0] src_data_next;
  logic [NSRC-1:0]   fwd_hit_next;
  logic              stall_next;

  assign ld_hit = bus.ld_valid & valid_reg[LD_STG] & ~ready_reg[LD_STG];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      if (gi == 0) begin : g_young
        always_ff @(posedge CLK) begin
          if (!nRST) begin
            valid_reg[gi] <= 1'b0;
            regwr_reg[gi] <= 1'b0;
            rd_reg[gi]    <= '0;
            ready_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
          end else if (bus.advance) begin
            valid_reg[gi] <= bus.issue_valid & ~bus.flush;
            regwr_reg[gi] <= bus.issue_regwr;
            rd_reg[gi]    <= bus.issue_rd;
            ready_reg[gi] <= ~bus.issue_is_load;
            data_reg[gi]  <= bus.issue_is_load ? '0 : bus.issue_data;
          end else if (bus.flush) begin
            valid_reg[gi] <= 1'b0;
          end
        end
      end else begin : g_older
        // Load data follows its entry: it lands one slot further on when the pipe moves.
        always_ff @(posedge CLK) begin
          if (!nRST) begin
            valid_reg[gi] <= 1'b0;
            regwr_reg[gi] <= 1'b0;
            rd_reg[gi]    <= '0;
            ready_reg[gi] <= 1'b0;
            data_reg[gi]  <= '0;
          end else if (bus.advance) begin
            valid_reg[gi] <= valid_reg[gi-1];
            regwr_reg[gi] <= regwr_reg[gi-1];
            rd_reg[gi]    <= rd_reg[gi-1];
            if (gi == LD_STG + 1 && ld_hit) begin
              ready_reg[gi] <= 1'b1;
              data_reg[gi]  <= bus.ld_data;
            end else begin
              ready_reg[gi] <= ready_reg[gi-1];
              data_reg[gi]  <= data_reg[gi-1];
            end
          end else if (gi == LD_STG && ld_hit) begin
            ready_reg[gi] <= 1'b1;
            data_reg[gi]  <= bus.ld_data;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    logic [REG_AW-1:0] sreg;
    logic              found;
    logic              rdy;
    logic [DW-1:0]     fdata;
    src_data_next = bus.src_rf_data;
    fwd_hit_next  = '0;
    stall_next    = 1'b0;
    sreg          = '0;
    found         = 1'b0;
    rdy           = 1'b0;
    fdata         = '0;
    for (int k = 0; k < NSRC; k++) begin
      sreg  = bus.src_reg[k*REG_AW +: REG_AW];
      found = 1'b0;
      rdy   = 1'b0;
      fdata = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid_reg[i] && regwr_reg[i] && (rd_reg[i] == sreg) && (sreg != '0)) begin
          found = 1'b1;
          rdy   = ready_reg[i];
          fdata = data_reg[i];
        end
      end
      fwd_hit_next[k] = found;
      if (found && rdy) begin
        src_data_next[k*DW +: DW] = fdata;
      end
      if (found && !rdy) begin
        stall_next = 1'b1;
      end
    end
  end

  assign bus.src_data = src_data_next;
  assign bus.fwd_hit  = fwd_hit_next;
  assign bus.stall    = stall_next;

`ifdef FWD_SCOREBOARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
    end else if (stall_next && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: reset, ALU forwarding, load-use, r0, flush/retire, reset mid-load.
module tb_fwd_scoreboard;

  localparam int REG_AW = 5;
  localparam int DW     = 32;
  localparam int NSRC   = 2;
  localparam logic [63:0] RF = 64'hBBBB_0001_AAAA_0000;

  logic clk;
  logic nrst;
  int   total;
  int   bad;
  logic [31:0] exp_cnt;

  fwd_scoreboard_if #(.REG_AW(REG_AW), .DW(DW), .NSRC(NSRC)) bus ();

  fwd_scoreboard #(.REG_AW(REG_AW), .DW(DW), .DEPTH(3), .NSRC(NSRC), .LD_STG(1)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic is_load, input logic [4:0] rd, input logic [31:0] data, input logic flush);
    bus.advance       = 1'b1;
    bus.issue_valid   = 1'b1;
    bus.issue_regwr   = 1'b1;
    bus.issue_is_load = is_load;
    bus.issue_rd      = rd;
    bus.issue_data    = data;
    bus.flush         = flush;
    tick();
    bus.advance       = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_is_load = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic bubble();
    bus.advance = 1'b1;
    tick();
    bus.advance = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef FWD_SCOREBOARD_PERF_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    nrst              = 1'b0;
    bus.advance       = 1'b0;
    bus.flush         = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_regwr   = 1'b0;
    bus.issue_is_load = 1'b0;
    bus.issue_rd      = '0;
    bus.issue_data    = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = '0;
    bus.src_reg       = '0;
    bus.src_rf_data   = RF;

    // Reset
    @(negedge clk);
    tick();
    tick();
    nrst = 1'b1;
    #1;
    check("rst_hit", 64'(bus.fwd_hit), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_data", bus.src_data, RF);
    check("rst_cnt", 64'(bus.stall_cnt), 64'd0);

    // ALU chain
    issue(1'b0, 5'd5, 32'h1234, 1'b0);
    bus.src_reg[4:0] = 5'd5;
    #1;
    check("alu_hit", 64'(bus.fwd_hit), 64'd1);
    check("alu_data", 64'(bus.src_data[31:0]), 64'h1234);
    issue(1'b0, 5'd5, 32'h5678, 1'b0);
    #1;
    check("young_wins", 64'(bus.src_data[31:0]), 64'h5678);

    // Load-use: load sits in entry 0, then bubbles into the load stage
    issue(1'b1, 5'd8, 32'hDEAD, 1'b0);
    bus.src_reg[9:5] = 5'd8;
    #1;
    check("ld_stall0", 64'(bus.stall), 64'd1);
    bus.src_reg[9:5] = 5'd0;
    bubble();
    bus.src_reg[9:5] = 5'd8;
    #1;
    check("ld_stall1", 64'(bus.stall), 64'd1);
    check("ld_pend_data", 64'(bus.src_data[63:32]), 64'hBBBB_0001);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hCAFE;
    tick();
    bus.ld_valid = 1'b0;
    #1;
    check("ld_stall_clr", 64'(bus.stall), 64'd0);
    check("ld_hit", 64'(bus.fwd_hit), 64'd3);
    check("ld_data", 64'(bus.src_data[63:32]), 64'hCAFE);
    check("ld_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
    bus.src_reg[9:5] = 5'd0;

    // Register zero never forwards
    issue(1'b0, 5'd0, 32'hFFFF, 1'b0);
    bus.src_reg[4:0] = 5'd0;
    #1;
    check("r0_hit", 64'(bus.fwd_hit), 64'd0);
    check("r0_data", 64'(bus.src_data[31:0]), 64'hAAAA_0000);

    // Flush while issuing, and flush while holding
    issue(1'b0, 5'd3, 32'h33, 1'b1);
    bus.src_reg[4:0] = 5'd3;
    #1;
    check("flush_adv", 64'(bus.fwd_hit), 64'd0);
    issue(1'b0, 5'd6, 32'h66, 1'b0);
    bus.src_reg[4:0] = 5'd6;
    #1;
    check("pre_flush_hold", 64'(bus.fwd_hit), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_hold", 64'(bus.fwd_hit), 64'd0);

    // Retire after DEPTH advances
    issue(1'b0, 5'd4, 32'h44, 1'b0);
    bus.src_reg[4:0] = 5'd4;
    #1;
    check("ret_e0", 64'(bus.src_data[31:0]), 64'h44);
    bubble();
    bubble();
    #1;
    check("ret_e2_hit", 64'(bus.fwd_hit), 64'd1);
    check("ret_e2_data", 64'(bus.src_data[31:0]), 64'h44);
    bubble();
    #1;
    check("ret_gone_hit", 64'(bus.fwd_hit), 64'd0);
    check("ret_gone_data", 64'(bus.src_data[31:0]), 64'hAAAA_0000);

    // Reset during a pending load
    bus.src_reg[4:0] = 5'd0;
    issue(1'b1, 5'd9, 32'h0, 1'b0);
    bubble();
    bus.src_reg[9:5] = 5'd9;
    #1;
    check("mid_stall", 64'(bus.stall), 64'd1);
    check("mid_cnt", 64'(bus.stall_cnt), 64'(exp_cnt));
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    #1;
    check("mid_rst_stall", 64'(bus.stall), 64'd0);
    check("mid_rst_hit", 64'(bus.fwd_hit), 64'd0);
    check("mid_rst_data", bus.src_data, RF);
    check("mid_rst_cnt", 64'(bus.stall_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
